// File: rtl/pwm_decode.sv
// PWM receiver: measures high time and period in prescaled ticks, decodes the high time to a scancode.
// Latency: valid and outputs update one clk after the tick that samples the rising edge. No backpressure.
// Optional PWM_DECODE_FILTER_EN: 3-tick glitch filter on the sampled level (edges shift by 2 ticks).
module pwm_decode #(
  parameter int PRESCALE = 625,
  parameter int CNT_W    = 10,
  parameter int TOL      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic [7:0]       scancode,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_MAX - ONE;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic            sync1, s;
  logic [PS_W-1:0] tcnt;
  logic            tick;
  logic            samp, prev;
  logic            rise, fall, timeout;
  logic [1:0]      state;
  logic [CNT_W-1:0] hc, pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
    end
  end

  assign tick = (tcnt == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + PS_W'(1);
  end

`ifdef PWM_DECODE_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     hist <= 2'b00;
    else if (tick) hist <= {hist[0], s};
  end

  // level only moves after three identical consecutive tick samples
  assign samp = (s == hist[0] && s == hist[1]) ? s : prev;
`else
  assign samp = s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     prev <= 1'b0;
    else if (tick) prev <= samp;
  end

  assign rise    = tick &  samp & ~prev;
  assign fall    = tick & ~samp &  prev;
  assign timeout = (pc >= CNT_TO);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + ONE;
  endfunction

  function automatic logic [7:0] decode(input logic [CNT_W-1:0] h);
    int v;
    v = int'(h);
    decode = 8'h00;
    if      (v >= 20 - TOL && v <= 20 + TOL) decode = 8'h2B;
    else if (v >= 25 - TOL && v <= 25 + TOL) decode = 8'h15;
    else if (v >= 30 - TOL && v <= 30 + TOL) decode = 8'h33;
    else if (v >= 80 - TOL && v <= 80 + TOL) decode = 8'h22;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hc           <= '0;
      pc           <= '0;
      high_ticks   <= '0;
      period_ticks <= '0;
      scancode     <= 8'h00;
      valid        <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick) begin
        if (stuck) stuck_level <= samp;
        case (state)
          IDLE: begin
            // pc doubles as the no-edge watchdog while waiting to arm
            if (rise) begin
              hc    <= ONE;
              pc    <= ONE;
              state <= HIGH;
            end else if (pc != CNT_MAX) begin
              pc <= pc + ONE;
              if (pc == CNT_TO) begin
                stuck       <= 1'b1;
                stuck_level <= samp;
              end
            end
          end
          HIGH: begin
            if (fall) begin
              pc    <= sat_inc(pc);
              state <= LOW;
            end else if (timeout) begin
              pc          <= CNT_MAX;
              stuck       <= 1'b1;
              stuck_level <= samp;
              state       <= IDLE;
            end else begin
              pc <= sat_inc(pc);
              hc <= sat_inc(hc);
            end
          end
          LOW: begin
            if (rise) begin
              high_ticks   <= hc;
              period_ticks <= pc;
              scancode     <= decode(hc);
              valid        <= 1'b1;
              stuck        <= 1'b0;
              hc           <= ONE;
              pc           <= ONE;
              state        <= HIGH;
            end else if (timeout) begin
              pc          <= CNT_MAX;
              stuck       <= 1'b1;
              stuck_level <= samp;
              state       <= IDLE;
            end else begin
              pc <= sat_inc(pc);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_pwm_decode;
  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_a, pwm_b;
  logic [9:0] high_a, per_a, high_b, per_b;
  logic [7:0] sc_a, sc_b;
  logic       valid_a, stuck_a, lvl_a, valid_b, stuck_b, lvl_b;

  pwm_decode #(.PRESCALE(1), .CNT_W(10), .TOL(2)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm_a), .high_ticks(high_a), .period_ticks(per_a),
    .scancode(sc_a), .valid(valid_a), .stuck(stuck_a), .stuck_level(lvl_a));

  pwm_decode #(.PRESCALE(3), .CNT_W(10), .TOL(2)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm_b), .high_ticks(high_b), .period_ticks(per_b),
    .scancode(sc_b), .valid(valid_b), .stuck(stuck_b), .stuck_level(lvl_b));

  always #5 clk = ~clk;

`ifdef PWM_DECODE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int qa_h[$], qa_p[$], qa_s[$], qa_st[$], qa_cyc[$];
  int qb_h[$], qb_p[$], qb_s[$], qb_cyc[$];
  int rise_a[$];
  int exp_h[$], exp_p[$], exp_s[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid_a) begin
      qa_h.push_back(int'(high_a));
      qa_p.push_back(int'(per_a));
      qa_s.push_back(int'(sc_a));
      qa_st.push_back(int'(stuck_a));
      qa_cyc.push_back(cyc);
    end
    if (valid_b) begin
      qb_h.push_back(int'(high_b));
      qb_p.push_back(int'(per_b));
      qb_s.push_back(int'(sc_b));
      qb_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one period on pwm_a, in clks (= ticks at PRESCALE=1); glitch is the offset of a forced-low clk
  task automatic period_a(input int hi, input int per, input int glitch);
    @(negedge clk);
    pwm_a = 1'b1;
    rise_a.push_back(cyc);
    for (int i = 1; i < per; i++) begin
      @(negedge clk);
      pwm_a = (i < hi && i != glitch);
    end
  endtask

  task automatic rise_only_a();
    @(negedge clk);
    pwm_a = 1'b1;
    rise_a.push_back(cyc);
  endtask

  task automatic period_b(input int hi, input int per);
    @(negedge clk);
    pwm_b = 1'b1;
    for (int i = 1; i < per; i++) begin
      @(negedge clk);
      pwm_b = (i < hi);
    end
  endtask

  initial begin
    int base;
    int n;
`ifdef PWM_DECODE_FILTER_EN
    exp_h = '{20, 20, 20, 25, 30, 80, 22, 50, 20, 20};
    exp_p = '{801, 801, 801, 801, 801, 801, 801, 801, 801, 801};
    exp_s = '{8'h2B, 8'h2B, 8'h2B, 8'h15, 8'h33, 8'h22, 8'h2B, 8'h00, 8'h2B, 8'h2B};
`else
    exp_h = '{20, 20, 20, 25, 30, 80, 22, 50, 10, 9, 20};
    exp_p = '{801, 801, 801, 801, 801, 801, 801, 801, 11, 790, 801};
    exp_s = '{8'h2B, 8'h2B, 8'h2B, 8'h15, 8'h33, 8'h22, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h2B};
`endif
    reset = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst high_ticks", int'(high_a), 0);
    check("rst period_ticks", int'(per_a), 0);
    check("rst scancode", int'(sc_a), 0);
    check("rst valid", int'(valid_a), 0);
    check("rst stuck", int'(stuck_a), 0);
    check("rst stuck_level", int'(lvl_a), 0);
    check("rst b stuck", int'(stuck_b), 0);
    check("rst b stuck_level", int'(lvl_b), 0);

    // constant low after reset: watchdog fires on tick 1023
    @(negedge clk);
    reset = 1'b0;
    repeat (1022) @(posedge clk);
    #1;
    check("stuck at tick 1022", int'(stuck_a), 0);
    @(posedge clk);
    #1;
    check("stuck at tick 1023", int'(stuck_a), 1);
    check("stuck_level low", int'(lvl_a), 0);
    repeat (77) @(posedge clk);
    #1;
    check("stuck held at 1100", int'(stuck_a), 1);
    check("high_ticks while stuck", int'(high_a), 0);
    check("no valid while stuck", qa_h.size(), 0);

    // stream: arm, three 20/801, then the scancode set, then a glitched period
    period_a(20, 801, -1);
    check("stuck after arm", int'(stuck_a), 1);
    period_a(20, 801, -1);
    period_a(20, 801, -1);
    period_a(25, 801, -1);
    period_a(30, 801, -1);
    period_a(80, 801, -1);
    period_a(22, 801, -1);
    period_a(50, 801, -1);
    period_a(20, 801, 10);
    period_a(20, 801, -1);
    rise_only_a();
    repeat (10) @(negedge clk);

    check("valid count", qa_h.size(), exp_h.size());
    for (int k = 0; k < exp_h.size(); k++) begin
      check($sformatf("rec%0d high_ticks", k), (k < qa_h.size()) ? qa_h[k] : -1, exp_h[k]);
      check($sformatf("rec%0d period_ticks", k), (k < qa_p.size()) ? qa_p[k] : -1, exp_p[k]);
      check($sformatf("rec%0d scancode", k), (k < qa_s.size()) ? qa_s[k] : -1, exp_s[k]);
      check($sformatf("rec%0d stuck", k), (k < qa_st.size()) ? qa_st[k] : -1, 0);
    end
    check("valid latency", (qa_cyc.size() > 0) ? qa_cyc[0] - rise_a[1] : -1, LAT);
    check("pulse spacing", (qa_cyc.size() > 1) ? qa_cyc[1] - qa_cyc[0] : -1, 801);

    // reset in the middle of a high phase
    @(negedge clk);
    reset = 1'b1;
    pwm_a = 1'b0;
    #1;
    check("midrst high_ticks", int'(high_a), 0);
    check("midrst period_ticks", int'(per_a), 0);
    check("midrst scancode", int'(sc_a), 0);
    check("midrst valid", int'(valid_a), 0);
    check("midrst stuck", int'(stuck_a), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = qa_h.size();
    period_a(20, 801, -1);
    check("post-rst arm only", qa_h.size(), base);
    period_a(20, 801, -1);
    check("post-rst first valid", qa_h.size(), base + 1);
    check("post-rst high_ticks", (qa_h.size() > base) ? qa_h[base] : -1, 20);
    check("post-rst period_ticks", (qa_p.size() > base) ? qa_p[base] : -1, 801);
    rise_only_a();
    repeat (10) @(negedge clk);
    check("post-rst second valid", qa_h.size(), base + 2);

    // PRESCALE=3: 20 ticks high = 60 clk, 801 ticks = 2403 clk
    period_b(60, 2403);
    period_b(60, 2403);
    @(negedge clk);
    pwm_b = 1'b1;
    repeat (20) @(negedge clk);
    n = qb_h.size();
    check("b valid count", n, 2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("b rec%0d high_ticks", k), (k < n) ? qb_h[k] : -1, 20);
      check($sformatf("b rec%0d period_ticks", k), (k < n) ? qb_p[k] : -1, 801);
      check($sformatf("b rec%0d scancode", k), (k < n) ? qb_s[k] : -1, 8'h2B);
    end
    check("b pulse spacing", (n > 1) ? qb_cyc[1] - qb_cyc[0] : -1, 2403);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
